// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg -- shared definitions for the serializer arbiter.
//
// Contents:
//   state_e           arbiter FSM state encoding
//   DEF_NUM_REQ       default number of requesters
//   DEF_DATA_W        default serializer word width
//   DEF_MOD_W         default length-field width
//   DEF_TIMEOUT_CYC   default watchdog limit (only used with SER_ARB_TIMEOUT_EN)
//   mod_is_valid()    legal length check: 1..data width inclusive

package ser_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_MOD_W       = 5;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  // A zero-length or over-long word cannot be shifted out by the serializer.
  function automatic logic mod_is_valid(input logic [31:0] mod, input int unsigned max_mod);
    return (mod != 32'd0) && (mod <= max_mod);
  endfunction

endpackage

// File: rtl/ser_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin selector.
//
// Ports:
//   req_i    in   NUM_REQ  request vector
//   last_i   in   IDX_W    index of the most recently granted requester
//   valid_o  out  1        at least one request is pending
//   grant_o  out  NUM_REQ  one-hot grant
//   idx_o    out  IDX_W    index of the granted requester
//
// The search starts at the requester after last_i and wraps, so a
// requester that was just served has the lowest priority next time.

module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter -- round-robin arbiter feeding a single word serializer.
//
// Ports:
//   clk_i       in   1                 clock
//   rst_i       in   1                 synchronous active-high reset
//   req_i       in   NUM_REQ           per-requester request, held until ack
//   req_data_i  in   NUM_REQ*DATA_W    per-requester word (slice r)
//   req_mod_i   in   NUM_REQ*MOD_W     per-requester bit count (slice r)
//   ack_o       out  NUM_REQ           one-cycle one-hot acceptance pulse
//   err_o       out  1                 with ack_o when the bit count is illegal
//   ser_data_o  out  DATA_W            word to the serializer
//   ser_mod_o   out  MOD_W             bit count to the serializer
//   ser_val_o   out  1                 one-cycle launch strobe
//   ser_busy_i  in   1                 serializer busy
//   owner_o     out  $clog2(NUM_REQ)   current/last granted requester
//   active_o    out  1                 a transfer is owned
//   timeout_o   out  1                 watchdog pulse
//
// Optional feature: define SER_ARB_TIMEOUT_EN to add a watchdog that
// abandons a transfer after TIMEOUT_CYC cycles in one wait state.

module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MOD_W       = DEF_MOD_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ*MOD_W-1:0]    req_mod_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic                        err_o,
  output logic [DATA_W-1:0]           ser_data_o,
  output logic [MOD_W-1:0]            ser_mod_o,
  output logic                        ser_val_o,
  input  logic                        ser_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        active_o,
  output logic                        timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [MOD_W-1:0]   mod_q, mod_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic               val_q, val_d;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  sel_data;
  logic [MOD_W-1:0]   sel_mod;
  logic               sel_mod_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (ptr_q),
    .valid_o (pick_valid),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  assign sel_data   = DATA_W'(req_data_i >> (32'(pick_idx) * DATA_W));
  assign sel_mod    = MOD_W'(req_mod_i >> (32'(pick_idx) * MOD_W));
  assign sel_mod_ok = mod_is_valid(32'(sel_mod), DATA_W);

`ifdef SER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Ack/err/val are registered so that the decision taken at the sampling
  // edge appears in the following cycle. A rejected request keeps the FSM in
  // IDLE but still moves the pointer so a bad requester cannot hog priority.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    mod_d   = mod_q;
    ack_d   = '0;
    err_d   = 1'b0;
    val_d   = 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ptr_d   = pick_idx;
          owner_d = pick_idx;
          ack_d   = pick_grant;
          if (sel_mod_ok) begin
            data_d  = sel_data;
            mod_d   = sel_mod;
            val_d   = 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (ser_busy_i)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!ser_busy_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

`ifdef SER_ARB_TIMEOUT_EN
    // The counter measures time spent in the current wait state only; any
    // state change leaves cnt_d at its cleared default.
    if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && state_d == state_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        timeout_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // Reset priority starts at requester 0, so the pointer holds the last index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

`ifdef SER_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  // Watchdog compiled out: the wait states hold until the serializer
  // answers. TIMEOUT_CYC is still referenced so the parameter stays visible.
  assign timeout_o = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign ser_val_o  = val_q;
  assign ser_data_o = data_q;
  assign ser_mod_o  = mod_q;
  assign owner_o    = owner_q;
  assign active_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ser_arbiter.sv
// tb_ser_arbiter -- self-checking bench for ser_arbiter.
//
// Directed scenarios followed by a randomized phase; every cycle's outputs
// are compared against a transaction-level model of the arbitration rules.
// Build with SER_ARB_TIMEOUT_EN defined to exercise the watchdog.

module tb_ser_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MW = 5;
  localparam int TO = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NR-1:0]      req_i;
  logic [NR*DW-1:0]   req_data_i;
  logic [NR*MW-1:0]   req_mod_i;
  logic [NR-1:0]      ack_o;
  logic               err_o;
  logic [DW-1:0]      ser_data_o;
  logic [MW-1:0]      ser_mod_o;
  logic               ser_val_o;
  logic               ser_busy_i;
  logic [1:0]         owner_o;
  logic               active_o;
  logic               timeout_o;

  always #5 clk_i = ~clk_i;

  ser_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .MOD_W       (MW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .req_mod_i  (req_mod_i),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .ser_data_o (ser_data_o),
    .ser_mod_o  (ser_mod_o),
    .ser_val_o  (ser_val_o),
    .ser_busy_i (ser_busy_i),
    .owner_o    (owner_o),
    .active_o   (active_o),
    .timeout_o  (timeout_o)
  );

  int checks = 0;
  int errors = 0;
  int cycleNum = 0;

  // Environment behaviour knobs
  bit holdAll = 1'b0;
  bit busyStuck = 1'b0;
  int busyLen = 5;
  int busyRemain = 0;
  logic [NR-1:0] ackSeen = '0;

  // Reference model state: who owns the serializer and how far the
  // handshake with it has progressed.
  int mLast = NR - 1;
  bit mOwned = 1'b0;
  bit mLaunch = 1'b0;
  bit mSeenBusy = 1'b0;
  int mPhase = 0;
  logic [NR-1:0] eAck = '0;
  bit eErr = 1'b0;
  bit eVal = 1'b0;
  bit eTo = 1'b0;
  int eOwner = 0;
  logic [DW-1:0] eData = '0;
  logic [MW-1:0] eMod = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got=%0h expected=%0h", tag, cycleNum, got, exp);
    end
  endtask

  function automatic bit bitOf(input logic [31:0] v, input int i);
    logic [31:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  function automatic void modelStep();
    int w;
    int m;
    eAck = '0;
    eErr = 1'b0;
    eVal = 1'b0;
    eTo  = 1'b0;
    if (rst_i) begin
      mOwned = 0; mLaunch = 0; mSeenBusy = 0; mPhase = 0;
      mLast = NR - 1; eOwner = 0; eData = '0; eMod = '0;
      return;
    end
    if (!mOwned) begin
      if (req_i != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++)
          if (w < 0 && bitOf(32'(req_i), (mLast + k) % NR)) w = (mLast + k) % NR;
        mLast  = w;
        eOwner = w;
        eAck   = NR'(1 << w);
        m = int'(MW'(req_mod_i >> (w * MW)));
        if (m >= 1 && m <= DW) begin
          mOwned = 1; mLaunch = 1; mSeenBusy = 0;
          eVal  = 1'b1;
          eData = DW'(req_data_i >> (w * DW));
          eMod  = MW'(m);
        end else begin
          eErr = 1'b1;
        end
      end
    end else if (mLaunch) begin
      mLaunch = 0;
      mPhase  = 0;
    end else begin
      mPhase++;
      if (!mSeenBusy && ser_busy_i) begin
        mSeenBusy = 1;
        mPhase    = 0;
      end else if (mSeenBusy && !ser_busy_i) begin
        mOwned = 0;
      end
`ifdef SER_ARB_TIMEOUT_EN
      else if (mPhase == TO) begin
        mOwned = 0;
        eTo    = 1'b1;
      end
`endif
    end
  endfunction

  task automatic setReq(input int r, input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_i[r] = 1'b1;
    req_data_i[r*DW +: DW] = d;
    req_mod_i[r*MW +: MW] = m;
  endtask

  // One clock: model and DUT step together, outputs are compared at the
  // falling edge, then requesters and the serializer react.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk_i);
    @(negedge clk_i);
    cycleNum++;
    checkOutput("ack", 32'(ack_o), 32'(eAck));
    checkOutput("err", 32'(err_o), 32'(eErr));
    checkOutput("val", 32'(ser_val_o), 32'(eVal));
    checkOutput("active", 32'(active_o), 32'(mOwned));
    checkOutput("owner", 32'(owner_o), eOwner);
    checkOutput("data", 32'(ser_data_o), 32'(eData));
    checkOutput("mod", 32'(ser_mod_o), 32'(eMod));
    checkOutput("timeout", 32'(timeout_o), 32'(eTo));
    ackSeen = ackSeen | ack_o;
    if (!holdAll) req_i = req_i & ~ack_o;
    if (busyStuck) begin
      ser_busy_i = 1'b1;
    end else if (ser_val_o) begin
      ser_busy_i = 1'b1;
      busyRemain = busyLen - 1;
    end else if (busyRemain > 0) begin
      busyRemain--;
      ser_busy_i = 1'b1;
    end else begin
      ser_busy_i = 1'b0;
    end
  endtask

  task automatic drainAll();
    for (int i = 0; i < 300 && (req_i != '0 || active_o); i++) applyStimulus();
    checkOutput("drain_done", 32'(req_i == '0 && !active_o), 32'd1);
  endtask

  initial begin
    int order[$];
    int idx;
    int launchCyc;
    int toCyc;
    int toCount;
    logic [MW-1:0] rm;

    rst_i = 1'b1;
    req_i = '0;
    req_data_i = '0;
    req_mod_i = '0;
    ser_busy_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_ack", 32'(ack_o), 32'd0);
    checkOutput("rst_active", 32'(active_o), 32'd0);
    checkOutput("rst_owner", 32'(owner_o), 32'd0);
    rst_i = 1'b0;
    applyStimulus();

    // Single request
    setReq(0, 16'hAAAA, 5'd4);
    applyStimulus();
    checkOutput("single_val", 32'(ser_val_o), 32'd1);
    checkOutput("single_data", 32'(ser_data_o), 32'hAAAA);
    checkOutput("single_mod", 32'(ser_mod_o), 32'd4);
    checkOutput("single_ack", 32'(ack_o), 32'b0001);
    checkOutput("single_owner", 32'(owner_o), 32'd0);
    drainAll();

    // All four held continuously, serializer busy 5 cycles per word
    rst_i = 1'b1;
    applyStimulus();
    rst_i = 1'b0;
    holdAll = 1'b1;
    busyLen = 5;
    for (int r = 0; r < NR; r++) setReq(r, DW'(16'h1000 + r), MW'(r + 1));
    for (int i = 0; i < 200 && order.size() < 5; i++) begin
      applyStimulus();
      checkOutput("ack_onehot", 32'($countones(ack_o) <= 1), 32'd1);
      if (ack_o != '0) begin
        idx = 0;
        for (int k = 0; k < NR; k++) if (bitOf(32'(ack_o), k)) idx = k;
        order.push_back(idx);
      end
    end
    for (int i = 0; i < 5; i++)
      checkOutput("rr_order", (i < order.size()) ? 32'(order[i]) : 32'd99, 32'(i % NR));
    req_i = '0;
    holdAll = 1'b0;
    drainAll();

    // Illegal lengths from requester 2
    setReq(2, 16'h5555, 5'd0);
    applyStimulus();
    checkOutput("mod0_ack", 32'(ack_o), 32'b0100);
    checkOutput("mod0_err", 32'(err_o), 32'd1);
    checkOutput("mod0_val", 32'(ser_val_o), 32'd0);
    setReq(2, 16'h5555, 5'd17);
    applyStimulus();
    checkOutput("mod17_ack", 32'(ack_o), 32'b0100);
    checkOutput("mod17_err", 32'(err_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("err_no_val", 32'(ser_val_o), 32'd0);
    end

    // Reset while waiting for the serializer to finish
    busyStuck = 1'b1;
    setReq(1, 16'h1111, 5'd5);
    for (int i = 0; i < 4; i++) applyStimulus();
    setReq(0, 16'h0A0A, 5'd7);
    setReq(2, 16'h2222, 5'd9);
    rst_i = 1'b1;
    applyStimulus();
    checkOutput("mid_rst_active", 32'(active_o), 32'd0);
    checkOutput("mid_rst_val", 32'(ser_val_o), 32'd0);
    checkOutput("mid_rst_ack", 32'(ack_o), 32'd0);
    checkOutput("mid_rst_data", 32'(ser_data_o), 32'd0);
    rst_i = 1'b0;
    busyStuck = 1'b0;
    applyStimulus();
    checkOutput("post_rst_ack", 32'(ack_o), 32'b0001);
    checkOutput("post_rst_data", 32'(ser_data_o), 32'h0A0A);
    drainAll();

    // Requester 1 withdraws just before the sampling edge
    setReq(0, 16'h0001, 5'd1);
    drainAll();
    ackSeen = '0;
    setReq(3, 16'h3333, 5'd3);
    setReq(1, 16'h1111, 5'd3);
    #2;
    req_i[1] = 1'b0;
    applyStimulus();
    checkOutput("drop_ack", 32'(ack_o), 32'b1000);
    checkOutput("drop_owner", 32'(owner_o), 32'd3);
    drainAll();
    checkOutput("drop_no_ack1", 32'(ackSeen[1]), 32'd0);

    // Serializer never finishes
    busyStuck = 1'b1;
    setReq(1, 16'hBEEF, 5'd16);
    applyStimulus();
    checkOutput("stuck_val", 32'(ser_val_o), 32'd1);
    launchCyc = cycleNum;
    toCyc = -1;
    toCount = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (timeout_o) begin
        toCount++;
        if (toCyc < 0) toCyc = cycleNum;
      end
    end
`ifdef SER_ARB_TIMEOUT_EN
    checkOutput("to_count", 32'(toCount), 32'd1);
    checkOutput("to_delay", 32'(toCyc - launchCyc), 32'd10);
    checkOutput("to_idle", 32'(active_o), 32'd0);
`else
    checkOutput("to_count", 32'(toCount), 32'd0);
    checkOutput("to_still_waiting", 32'(active_o), 32'd1);
`endif
    busyStuck = 1'b0;
    drainAll();

    // Randomized traffic, drops, illegal lengths and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(199) == 0);
      busyLen = $urandom_range(6, 2);
      for (int r = 0; r < NR; r++) begin
        if (!req_i[r] && $urandom_range(3) == 0) begin
          if ($urandom_range(9) == 0) rm = ($urandom_range(1) == 0) ? MW'(0) : MW'($urandom_range(31, 17));
          else rm = MW'($urandom_range(DW, 1));
          setReq(r, DW'($urandom), rm);
        end else if (req_i[r] && $urandom_range(29) == 0) begin
          req_i[r] = 1'b0;
        end
      end
      applyStimulus();
      checkOutput("rand_onehot", 32'($countones(ack_o) <= 1), 32'd1);
    end
    rst_i = 1'b0;
    req_i = '0;
    drainAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, serializer word width.
REQ-003 SHALL have parameter MOD_W, default 5, length-field width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, watchdog limit in cycles (used only with SER_ARB_TIMEOUT_EN).
REQ-005 SHALL have the following ports:
- clk_i  in  1  the single clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester request, held until ack.
- req_data_i  in  NUM_REQ*DATA_W  per-requester word, requester r at slice r.
- req_mod_i  in  NUM_REQ*MOD_W  per-requester bit count.
- ack_o  out  NUM_REQ  one-cycle acceptance pulse, one-hot.
- err_o  out  1  pulses with ack_o when the request was rejected.
- ser_data_o  out  DATA_W  word to the serializer.
- ser_mod_o  out  MOD_W  bit count to the serializer.
- ser_val_o  out  1  one-cycle launch strobe to the serializer.
- ser_busy_i  in  1  serializer busy.
- owner_o  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- active_o  out  1  high while a transfer is owned.
- timeout_o  out  1  watchdog pulse.

Function
REQ-006 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-007 In IDLE with any req_i high, SHALL select one requester round-robin, searching from the requester after the last granted one, and latch its data and mod into ser_data_o/ser_mod_o.
REQ-008 Valid mod SHALL be 1..DATA_W. Mod 0 or mod > DATA_W SHALL pulse ack_o[r] and err_o in the next cycle, with no launch; the FSM SHALL stay in IDLE and the pointer SHALL advance.
REQ-009 For a valid request, the FSM SHALL enter LAUNCH; in LAUNCH, ser_val_o=1 and ack_o[r]=1 for exactly one cycle, then WAIT_BUSY.
REQ-010 Latency: request sampled at edge k, then ser_val_o/ack_o high in cycle k+1.
REQ-011 WAIT_BUSY -> WAIT_DONE on ser_busy_i=1; WAIT_DONE -> IDLE on ser_busy_i=0.
REQ-012 ser_data_o/ser_mod_o SHALL stay stable from LAUNCH until IDLE is re-entered.
REQ-013 active_o SHALL be 1 in LAUNCH, WAIT_BUSY and WAIT_DONE, and 0 in IDLE.
REQ-014 req_i dropped before its ack SHALL be ignored, never partially served; at most one ack_o bit is high per cycle.
REQ-015 Requests arriving while active_o=1 SHALL wait; no grant is issued while active_o=1.
REQ-016 With all NUM_REQ requesters asserted continuously, grants SHALL cycle 0,1,..,NUM_REQ-1,0 (no starvation).

Reset
REQ-017 On rst_i sampled high, regardless of state, the block SHALL reset:
- FSM to IDLE.
- Round-robin pointer so requester 0 has top priority.
- ack_o, err_o, ser_val_o, active_o and timeout_o to 0.
- ser_data_o, ser_mod_o and owner_o to 0.
REQ-018 Reset mid-transfer SHALL NOT emit a further ack_o or ser_val_o; the in-flight transfer is abandoned.

Configuration
REQ-019 Macro SER_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT_CYC SHALL pulse timeout_o one cycle and force IDLE. The counter SHALL clear on every state entry.
REQ-020 Macro SER_ARB_TIMEOUT_EN undefined: no counter SHALL exist, timeout_o SHALL be tied 0, and WAIT states wait indefinitely.

Structure
REQ-021 Package ser_arb_pkg SHALL hold the state enum typedef, default DATA_W/MOD_W constants and the timeout default.
REQ-022 Round-robin selection SHALL be a sub-module rr_pick (req vector + pointer in, one-hot grant + index out, combinational); ser_arbiter owns the pointer and FSM.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single request: req_i=0001, data 16'hAAAA, mod 4. Response: ser_val_o one cycle later with ser_data_o=AAAA, ser_mod_o=4, ack_o=0001, owner_o=0.
- All four requesters held, with a serializer model busy 5 cycles per transfer. Response: ack order 0,1,2,3,0; never two acks in one cycle.
- Requester 2 with mod 0, then mod 17. Response: ack_o=0100 with err_o=1 each time; ser_val_o never asserted.
- rst_i asserted during WAIT_DONE. Response: next cycle IDLE, all outputs 0, next grant goes to requester 0.
- With SER_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, ser_busy_i stuck 1. Response: timeout_o pulses 8 cycles after WAIT_BUSY exit, then the FSM is in IDLE. Without the macro, the FSM is still in WAIT_DONE after 100 cycles.
- req_i[1] dropped in the cycle of its sampling edge while requester 3 is also requesting. Response: requester 3 is served; no ack to requester 1.
